// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one unified RAM port between CPU fetch (if_),
// CPU data (d_) and the program loader (ld_). Fixed priority ld > d > if,
// with a starvation guard that forces a fetch grant after STARVE_MAX
// consecutive data grants. One access per three cycles: IDLE, ACCESS, RESP.
// Optional feature macro: RAM_ARB_WRITE_PROTECT_EN (reject data-port stores
// below PROT_LIMIT, flagged with d_err alongside d_ack).
module ram_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
`ifdef RAM_ARB_WRITE_PROTECT_EN
  ,
  parameter logic [31:0] PROT_LIMIT = 32'h0000_00C0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {ID_NONE, ID_IF, ID_D, ID_LD} id_t;

  state_t            r_state,      w_state_nxt;
  id_t               r_id,         w_id_nxt;
  logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
  logic [DATA_W-1:0] r_wdata,      w_wdata_nxt;
  logic              r_we,         w_we_nxt;
  logic [CNT_W-1:0]  r_starve_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_if_rdata,   w_if_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata,    w_d_rdata_nxt;
  logic              r_m_we,       w_m_we_nxt;
  logic              r_if_ack,     w_if_ack_nxt;
  logic              r_d_ack,      w_d_ack_nxt;
  logic              r_ld_ack,     w_ld_ack_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              w_starved;
`ifdef RAM_ARB_WRITE_PROTECT_EN
  logic              r_prot,       w_prot_nxt;
  logic              r_d_err,      w_d_err_nxt;
`endif

  // Next-state, arbitration and registered-output computation
  always_comb begin
    w_state_nxt    = r_state;
    w_id_nxt       = r_id;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_we_nxt       = r_we;
    w_cnt_nxt      = r_starve_cnt;
    w_if_rdata_nxt = r_if_rdata;
    w_d_rdata_nxt  = r_d_rdata;
    w_m_we_nxt     = 1'b0;
    w_if_ack_nxt   = 1'b0;
    w_d_ack_nxt    = 1'b0;
    w_ld_ack_nxt   = 1'b0;
    w_busy_nxt     = 1'b0;
`ifdef RAM_ARB_WRITE_PROTECT_EN
    w_prot_nxt     = r_prot;
    w_d_err_nxt    = 1'b0;
`endif
    w_starved      = if_req && (r_starve_cnt == CNT_W'(STARVE_MAX));

    case (r_state)
      S_IDLE: begin
        if (!if_req) begin
          w_cnt_nxt = '0;
        end
        if (ld_req) begin
          w_id_nxt    = ID_LD;
          w_addr_nxt  = ld_addr;
          w_wdata_nxt = ld_wdata;
          w_we_nxt    = 1'b1;
`ifdef RAM_ARB_WRITE_PROTECT_EN
          w_prot_nxt  = 1'b0;
`endif
        end else if (d_req && !w_starved) begin
          w_id_nxt    = ID_D;
          w_addr_nxt  = d_addr;
          w_wdata_nxt = d_wdata;
          w_we_nxt    = d_we;
`ifdef RAM_ARB_WRITE_PROTECT_EN
          w_prot_nxt  = d_we && (d_addr < ADDR_W'(PROT_LIMIT));
`endif
          if (if_req && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
            w_cnt_nxt = r_starve_cnt + CNT_W'(1);
          end
        end else if (if_req) begin
          w_id_nxt   = ID_IF;
          w_addr_nxt = if_addr;
          w_we_nxt   = 1'b0;
          w_cnt_nxt  = '0;
`ifdef RAM_ARB_WRITE_PROTECT_EN
          w_prot_nxt = 1'b0;
`endif
        end
        if (ld_req || d_req || if_req) begin
          w_state_nxt = S_ACCESS;
          w_busy_nxt  = 1'b1;
`ifdef RAM_ARB_WRITE_PROTECT_EN
          w_m_we_nxt  = w_we_nxt & ~w_prot_nxt;
`else
          w_m_we_nxt  = w_we_nxt;
`endif
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_RESP;
        w_busy_nxt  = 1'b1;
        case (r_id)
          ID_IF: begin
            w_if_ack_nxt   = 1'b1;
            w_if_rdata_nxt = m_rdata;
          end
          ID_D: begin
            w_d_ack_nxt = 1'b1;
            if (!r_we) begin
              w_d_rdata_nxt = m_rdata;
            end
`ifdef RAM_ARB_WRITE_PROTECT_EN
            w_d_err_nxt = r_prot;
`endif
          end
          ID_LD: begin
            w_ld_ack_nxt = 1'b1;
          end
          default: begin
            w_state_nxt = S_RESP;
          end
        endcase
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_id         <= ID_NONE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_starve_cnt <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_m_we       <= 1'b0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_ld_ack     <= 1'b0;
      r_busy       <= 1'b0;
`ifdef RAM_ARB_WRITE_PROTECT_EN
      r_prot       <= 1'b0;
      r_d_err      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_id         <= w_id_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_we         <= w_we_nxt;
      r_starve_cnt <= w_cnt_nxt;
      r_if_rdata   <= w_if_rdata_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
      r_m_we       <= w_m_we_nxt;
      r_if_ack     <= w_if_ack_nxt;
      r_d_ack      <= w_d_ack_nxt;
      r_ld_ack     <= w_ld_ack_nxt;
      r_busy       <= w_busy_nxt;
`ifdef RAM_ARB_WRITE_PROTECT_EN
      r_prot       <= w_prot_nxt;
      r_d_err      <= w_d_err_nxt;
`endif
    end
  end

  assign if_ack   = r_if_ack;
  assign if_rdata = r_if_rdata;
  assign d_ack    = r_d_ack;
  assign d_rdata  = r_d_rdata;
  assign ld_ack   = r_ld_ack;
  assign m_addr   = r_addr;
  assign m_wdata  = r_wdata;
  assign m_we     = r_m_we;
  assign busy     = r_busy;
`ifdef RAM_ARB_WRITE_PROTECT_EN
  assign d_err    = r_d_err;
`else
  assign d_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a small behavioural RAM
// (combinational read, write on the falling edge).
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ack;
  logic [31:0] m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        busy;

  logic [31:0] ram [0:255];
  int          n_checks;
  int          n_pass;

  ram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_rdata = ram[m_addr[9:2]];

  // RAM model: preload, then write on falling edge when m_we is high
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[0]  = 32'h201D_0200;
    ram[16] = 32'h5555_AAAA;
    forever begin
      @(negedge clk);
      if (m_we) ram[m_addr[9:2]] = m_wdata;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({if_ack, d_ack, ld_ack} !== 3'b000) $display("FAIL reset_acks got=%b exp=000", {if_ack, d_ack, ld_ack}); else n_pass++;
    n_checks++; if ({m_we, busy, d_err} !== 3'b000) $display("FAIL reset_we_busy_err got=%b exp=000", {m_we, busy, d_err}); else n_pass++;
    n_checks++; if (m_addr !== 32'h0) $display("FAIL reset_m_addr got=%h exp=0", m_addr); else n_pass++;
    n_checks++; if (m_wdata !== 32'h0) $display("FAIL reset_m_wdata got=%h exp=0", m_wdata); else n_pass++;
    n_checks++; if ({if_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata got=%h exp=0", {if_rdata, d_rdata}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    n_checks++; if ({busy, m_we, if_ack} !== 3'b100) $display("FAIL fetch_access got=%b exp=100", {busy, m_we, if_ack}); else n_pass++;
    n_checks++; if (m_addr !== 32'h0) $display("FAIL fetch_m_addr got=%h exp=0", m_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if ({if_ack, m_we} !== 2'b10) $display("FAIL fetch_ack got=%b exp=10", {if_ack, m_we}); else n_pass++;
    n_checks++; if (if_rdata !== 32'h201D_0200) $display("FAIL fetch_rdata got=%h exp=201d0200", if_rdata); else n_pass++;
    if_req = 1'b0;
    @(negedge clk);
    n_checks++; if ({if_ack, busy, m_we} !== 3'b000) $display("FAIL fetch_idle got=%b exp=000", {if_ack, busy, m_we}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if ({m_we, d_ack} !== 2'b10) $display("FAIL store_access got=%b exp=10", {m_we, d_ack}); else n_pass++;
    n_checks++; if ({m_addr, m_wdata} !== {32'h100, 32'hDEAD_BEEF}) $display("FAIL store_bus got=%h exp=00000100deadbeef", {m_addr, m_wdata}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({d_ack, m_we} !== 2'b10) $display("FAIL store_ack got=%b exp=10", {d_ack, m_we}); else n_pass++;
    n_checks++; if (d_rdata !== 32'h0) $display("FAIL store_keeps_rdata got=%h exp=0", d_rdata); else n_pass++;
    n_checks++; if (ram[64] !== 32'hDEAD_BEEF) $display("FAIL store_ram got=%h exp=deadbeef", ram[64]); else n_pass++;
    d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0;
    @(negedge clk);
    n_checks++; if ({m_we, d_ack} !== 2'b00) $display("FAIL load_access got=%b exp=00", {m_we, d_ack}); else n_pass++;
    @(negedge clk);
    n_checks++; if (d_ack !== 1'b1) $display("FAIL load_ack got=%b exp=1", d_ack); else n_pass++;
    n_checks++; if (d_rdata !== 32'hDEAD_BEEF) $display("FAIL load_rdata got=%h exp=deadbeef", d_rdata); else n_pass++;
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_priority();
    logic [2:0] exp;
    ld_req = 1'b1; ld_addr = 32'h200; ld_wdata = 32'h1111_2222;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp = (k == 2) ? 3'b100 : (k == 5) ? 3'b010 : (k == 8) ? 3'b001 : 3'b000;
      n_checks++; if ({ld_ack, d_ack, if_ack} !== exp) $display("FAIL prio_acks cycle=%0d got=%b exp=%b", k, {ld_ack, d_ack, if_ack}, exp); else n_pass++;
      if (ld_ack) ld_req = 1'b0;
      if (d_ack) begin
        d_req = 1'b0;
        n_checks++; if (d_rdata !== 32'hDEAD_BEEF) $display("FAIL prio_d_rdata got=%h exp=deadbeef", d_rdata); else n_pass++;
      end
      if (if_ack) begin
        if_req = 1'b0;
        n_checks++; if (if_rdata !== 32'h201D_0200) $display("FAIL prio_if_rdata got=%h exp=201d0200", if_rdata); else n_pass++;
      end
    end
    ld_req = 1'b0; d_req = 1'b0; if_req = 1'b0;
    n_checks++; if (ram[128] !== 32'h1111_2222) $display("FAIL prio_ld_ram got=%h exp=11112222", ram[128]); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int idx;
    logic [1:0] exp;
    idx = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h0;
    for (int c = 0; c < 60 && idx < 15; c++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        exp = ((idx % 5) == 4) ? 2'b01 : 2'b10;
        n_checks++; if ({d_ack, if_ack} !== exp) $display("FAIL starve_order txn=%0d got=%b exp=%b", idx, {d_ack, if_ack}, exp); else n_pass++;
        idx++;
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    n_checks++; if (idx != 15) $display("FAIL starve_timeout acks=%0d exp=15", idx); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL starve_idle busy=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_mid_busy got=%b exp=1", busy); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({d_ack, busy, m_we} !== 3'b000) $display("FAIL rst_mid_flags got=%b exp=000", {d_ack, busy, m_we}); else n_pass++;
    n_checks++; if ({d_rdata, m_addr} !== 64'h0) $display("FAIL rst_mid_regs got=%h exp=0", {d_rdata, m_addr}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if ({busy, d_ack} !== 2'b10) $display("FAIL rst_mid_retry_access got=%b exp=10", {busy, d_ack}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({d_ack, d_rdata} !== {1'b1, 32'hDEAD_BEEF}) $display("FAIL rst_mid_retry_ack got=%h exp=1deadbeef", {d_ack, d_rdata}); else n_pass++;
    d_req = 1'b0;
    @(negedge clk);
  endtask

`ifdef RAM_ARB_WRITE_PROTECT_EN
  task automatic test_protect();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_checks++; if (m_we !== 1'b0) $display("FAIL prot_low_we got=%b exp=0", m_we); else n_pass++;
    @(negedge clk);
    n_checks++; if ({d_ack, d_err} !== 2'b11) $display("FAIL prot_low_ack_err got=%b exp=11", {d_ack, d_err}); else n_pass++;
    n_checks++; if (ram[16] !== 32'h5555_AAAA) $display("FAIL prot_low_ram got=%h exp=5555aaaa", ram[16]); else n_pass++;
    d_req = 1'b0;
    @(negedge clk);
    n_checks++; if (d_err !== 1'b0) $display("FAIL prot_err_pulse got=%b exp=0", d_err); else n_pass++;
    d_req = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    n_checks++; if ({d_ack, d_err} !== 2'b10) $display("FAIL prot_high_ack_err got=%b exp=10", {d_ack, d_err}); else n_pass++;
    n_checks++; if (ram[64] !== 32'h1234_5678) $display("FAIL prot_high_ram got=%h exp=12345678", ram[64]); else n_pass++;
    d_req = 1'b0;
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 32'h44; ld_wdata = 32'h0BAD_CAFE;
    repeat (2) @(negedge clk);
    n_checks++; if ({ld_ack, d_err} !== 2'b10) $display("FAIL prot_ld_ack got=%b exp=10", {ld_ack, d_err}); else n_pass++;
    n_checks++; if (ram[17] !== 32'h0BAD_CAFE) $display("FAIL prot_ld_ram got=%h exp=0badcafe", ram[17]); else n_pass++;
    ld_req = 1'b0;
    @(negedge clk);
  endtask
`else
  task automatic test_protect();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_checks++; if (m_we !== 1'b1) $display("FAIL noprot_we got=%b exp=1", m_we); else n_pass++;
    @(negedge clk);
    n_checks++; if ({d_ack, d_err} !== 2'b10) $display("FAIL noprot_ack_err got=%b exp=10", {d_ack, d_err}); else n_pass++;
    n_checks++; if (ram[16] !== 32'hCAFE_F00D) $display("FAIL noprot_ram got=%h exp=cafef00d", ram[16]); else n_pass++;
    d_req = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    ld_req = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
    test_reset();
    test_fetch();
    test_back_to_back();
    test_priority();
    test_starvation();
    test_reset_mid_access();
    test_protect();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
